// File: rtl/simmem_pkg.sv
// Shared configuration for the simulated-memory linked-list response bank.
// The default configuration, the slot/count types and the position of the ID field in a message.
package simmem_pkg;

  localparam int DefStructWidth = 64;
  localparam int DefCapacity    = 512;
  localparam int DefIdWidth     = 4;

  localparam int DefAddrWidth = $clog2(DefCapacity);
  localparam int DefCntWidth  = $clog2(DefCapacity + 1);

  // The ID occupies the low bits of every message.
  localparam int IdLsb = 0;

  typedef logic [DefAddrWidth-1:0] addr_t;
  typedef logic [DefCntWidth-1:0]  cnt_t;

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last accepted grant.
// The pointer moves only when the grant is accepted.
module simmem_rr_arbiter #(
  parameter int N = 16,
  localparam int IdxWidth = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic                accept,
  output logic [N-1:0]        gnt,
  output logic [IdxWidth-1:0] gnt_idx
);

  logic [IdxWidth-1:0] ptr_q;
  logic [IdxWidth-1:0] cand;

  // Walk from the farthest offset to the nearest, so the nearest requester wins.
  // Offset N wraps back to ptr_q itself, which gives the last grant the lowest priority.
  always_comb begin
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int off = N; off >= 1; off--) begin
      cand = ptr_q + IdxWidth'(off);
      if (req[cand]) gnt_idx = cand;
    end
    gnt = '0;
    if (|req) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/simmem_linkedlist_bank_rr.sv
// Shared-storage response bank: one linked-list FIFO per ID over a common payload RAM.
// Round-robin release among the enabled IDs, followed by a registered output stage.
module simmem_linkedlist_bank_rr
  import simmem_pkg::*;
#(
  parameter int StructWidth = DefStructWidth,
  parameter int Capacity    = DefCapacity,
  parameter int IdWidth     = DefIdWidth,
  localparam int NumIds     = 2 ** IdWidth,
  localparam int AddrWidth  = $clog2(Capacity),
  localparam int CntWidth   = $clog2(Capacity + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumIds-1:0]      release_en_i,
  input  logic [StructWidth-1:0] data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [StructWidth-1:0] data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [CntWidth-1:0]    free_cnt_o
);

  localparam int PayWidth = StructWidth - IdWidth;

  logic [PayWidth-1:0]    mem [Capacity];
  logic [AddrWidth-1:0]   next_q [Capacity];
  logic [AddrWidth-1:0]   head_q [NumIds];
  logic [AddrWidth-1:0]   tail_q [NumIds];
  logic [CntWidth-1:0]    len_q  [NumIds];

  logic [Capacity-1:0]    free_q;
  logic [CntWidth-1:0]    free_cnt_q;
  logic                   rel_pend_q;
  logic                   out_valid_q;
  logic [StructWidth-1:0] data_q;

  logic [AddrWidth-1:0]   alloc_slot;
  logic [AddrWidth-1:0]   fetch_slot;
  logic [IdWidth-1:0]     enq_id;
  logic [IdWidth-1:0]     gnt_idx;
  logic [NumIds-1:0]      req;
  logic [NumIds-1:0]      gnt;
  logic [NumIds-1:0]      enq_hit;
  logic [NumIds-1:0]      fetch_hit;
  logic                   enq;
  logic                   fetch;

  assign in_ready_o  = (free_cnt_q != '0);
  assign enq         = in_valid_i && in_ready_o;
  assign enq_id      = data_i[IdLsb +: IdWidth];
  assign out_valid_o = out_valid_q;
  assign data_o      = data_q;
  assign free_cnt_o  = free_cnt_q;

  // Lowest-index free slot: scan from the top so that the lowest set bit is assigned last.
  always_comb begin
    alloc_slot = '0;
    for (int i = Capacity - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_slot = AddrWidth'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      req[i] = release_en_i[i] && (len_q[i] != '0);
    end
  end

  assign fetch      = (!out_valid_q || out_ready_i) && (|req);
  assign fetch_slot = head_q[gnt_idx];
  assign fetch_hit  = fetch ? gnt : '0;

  always_comb begin
    enq_hit = '0;
    if (enq) enq_hit[enq_id] = 1'b1;
  end

  simmem_rr_arbiter #(
    .N(NumIds)
  ) u_arb (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .req    (req),
    .accept (fetch),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  always_ff @(posedge clk_i) begin
    if (enq) mem[alloc_slot] <= data_i[StructWidth-1:IdLsb+IdWidth];
  end

  // Link the new slot behind the current tail; an empty list has no tail to link from.
  always_ff @(posedge clk_i) begin
    if (enq && (len_q[enq_id] != '0)) next_q[tail_q[enq_id]] <= alloc_slot;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIds; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        len_q[i]  <= '0;
      end
      free_q      <= '1;
      free_cnt_q  <= CntWidth'(Capacity);
      rel_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        // If the last entry leaves while a new one arrives, next[head] is not linked yet.
        // The head therefore takes the new slot directly.
        if (enq_hit[i] && ((len_q[i] == '0) ||
                           (fetch_hit[i] && (len_q[i] == CntWidth'(1))))) begin
          head_q[i] <= alloc_slot;
        end else if (fetch_hit[i]) begin
          head_q[i] <= next_q[head_q[i]];
        end
        if (enq_hit[i]) tail_q[i] <= alloc_slot;
        if (enq_hit[i] && !fetch_hit[i]) begin
          len_q[i] <= len_q[i] + CntWidth'(1);
        end else if (!enq_hit[i] && fetch_hit[i]) begin
          len_q[i] <= len_q[i] - CntWidth'(1);
        end
      end

      if (enq) free_q[alloc_slot] <= 1'b0;
      // The payload is captured at this edge, so the slot can be rewritten from the next cycle on.
      if (fetch) free_q[fetch_slot] <= 1'b1;
      rel_pend_q <= fetch;
      free_cnt_q <= free_cnt_q - CntWidth'(enq) + CntWidth'(rel_pend_q);

      if (fetch) begin
        out_valid_q <= 1'b1;
        data_q      <= {mem[fetch_slot], gnt_idx};
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
